// File: rtl/spidergon_output_arbiter_if.sv
// Handshake bundle between the input-VC requesters and one output arbiter.
// master drives requests and credit returns; slave (the arbiter) drives
// grant, grant_vc, vc_busy, credit_count and credit_error.
interface spidergon_output_arbiter_if #(
    parameter int N  = 8,
    parameter int V  = 2,
    parameter int VW = 1,
    parameter int CW = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_head;
    logic [N-1:0]    req_tail;
    logic [V-1:0]    credit_return;
    logic [N-1:0]    grant;
    logic [VW-1:0]   grant_vc;
    logic [V-1:0]    vc_busy;
    logic [V*CW-1:0] credit_count;
    logic            credit_error;

    modport master (
        output req, req_head, req_tail, credit_return,
        input  grant, grant_vc, vc_busy, credit_count, credit_error
    );

    modport slave (
        input  req, req_head, req_tail, credit_return,
        output grant, grant_vc, vc_busy, credit_count, credit_error
    );
endinterface

// File: rtl/spidergon_output_arbiter.sv
// Round-robin switch arbiter for one Spidergon output port with wormhole
// VC locking and optional credit flow control (SPIDERGON_ARB_CREDIT_EN).
// Ports: clk, reset (async, active-high), arb_if (slave): req/req_head/
// req_tail/credit_return in; grant/grant_vc/vc_busy/credit_count/
// credit_error out.
module spidergon_output_arbiter #(
    parameter int NUM_OF_INPUT_PORTS      = 4,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NODE_BUFFER_WIDTH       = 32
) (
    input  logic clk,
    input  logic reset,
    spidergon_output_arbiter_if.slave arb_if
);
    localparam int N     = NUM_OF_INPUT_PORTS * NUM_OF_VIRTUAL_CHANNELS;
    localparam int V     = NUM_OF_VIRTUAL_CHANNELS;
    localparam int DEPTH = NODE_BUFFER_WIDTH / FLIT_DATA_WIDTH;
    localparam int VW    = (V > 1) ? $clog2(V) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW:0]   NP   = (PW+1)'(N);

    logic [PW-1:0] r_ptr;
    logic [V-1:0]  r_lock;
    logic [PW-1:0] r_owner [V];

    logic [V-1:0]  w_cred_ok;
    logic [N-1:0]  w_elig;
    logic          w_found;
    logic [PW:0]   w_idx;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_any;
    logic [N-1:0]  w_grant;
    logic [VW-1:0] w_gvc;
    logic          w_head;
    logic          w_tail;

    // Locked VCs accept only their owner; idle VCs accept only heads.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_if.req[i] && w_cred_ok[i % V]) begin
                if (r_lock[i % V])
                    w_elig[i] = (r_owner[i % V] == PW'(i));
                else
                    w_elig[i] = arb_if.req_head[i];
            end
        end
    end

    // First eligible index starting at r_ptr, wrapping mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= NP)
                w_idx = w_idx - NP;
            if (!w_found && w_elig[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    assign w_any     = w_found && !reset;
    assign w_grant   = w_any ? (N'(1) << w_win) : '0;
    assign w_ptr_nxt = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    assign w_head    = arb_if.req_head[w_win];
    assign w_tail    = arb_if.req_tail[w_win];

    always_comb begin
        w_gvc = '0;
        for (int i = 0; i < N; i++)
            if (w_grant[i])
                w_gvc = VW'(i % V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= '0;
            r_lock <= '0;
            for (int v = 0; v < V; v++)
                r_owner[v] <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
            if (w_tail) begin
                r_lock[w_gvc] <= 1'b0;
            end else if (w_head) begin
                r_lock[w_gvc]  <= 1'b1;
                r_owner[w_gvc] <= w_win;
            end
        end
    end

    assign arb_if.grant    = w_grant;
    assign arb_if.grant_vc = w_gvc;
    assign arb_if.vc_busy  = r_lock;

`ifdef SPIDERGON_ARB_CREDIT_EN
    logic [CW-1:0] r_credit [V];
    logic          r_credit_error;
    logic [V-1:0]  w_dec;

    always_comb begin
        w_cred_ok = '0;
        w_dec     = '0;
        for (int v = 0; v < V; v++) begin
            w_cred_ok[v] = (r_credit[v] != '0);
            w_dec[v]     = w_any && (w_gvc == VW'(v));
        end
    end

    // Grant and return in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit_error <= 1'b0;
            for (int v = 0; v < V; v++)
                r_credit[v] <= FULL;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (arb_if.credit_return[v] && !w_dec[v]) begin
                    if (r_credit[v] == FULL)
                        r_credit_error <= 1'b1;
                    else
                        r_credit[v] <= r_credit[v] + 1'b1;
                end else if (!arb_if.credit_return[v] && w_dec[v]) begin
                    r_credit[v] <= r_credit[v] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        arb_if.credit_count = '0;
        for (int v = 0; v < V; v++)
            arb_if.credit_count[v*CW +: CW] = r_credit[v];
    end

    assign arb_if.credit_error = r_credit_error;
`else
    logic w_unused;

    assign w_unused            = ^arb_if.credit_return;
    assign w_cred_ok           = '1;
    assign arb_if.credit_count = {V{FULL}};
    assign arb_if.credit_error = 1'b0;
`endif
endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// Self-checking bench for spidergon_output_arbiter: directed scenarios
// plus randomized packet traffic against a behavioural model.
module tb_spidergon_output_arbiter;
    localparam int N     = 8;
    localparam int V     = 2;
    localparam int DEPTH = 2;
`ifdef SPIDERGON_ARB_CREDIT_EN
    localparam bit CRED_EN = 1'b1;
`else
    localparam bit CRED_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spidergon_output_arbiter_if #(.N(N), .V(V), .VW(1), .CW(2)) bus ();

    spidergon_output_arbiter #(
        .NUM_OF_INPUT_PORTS(4),
        .NUM_OF_VIRTUAL_CHANNELS(2),
        .FLIT_DATA_WIDTH(16),
        .NODE_BUFFER_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arb_if(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int m_owner [V];
    int m_cred  [V];
    int m_ptr;
    bit m_err;

    int p_len [N];
    int p_idx [N];
    bit p_act [N];
    bit p_rep [N];
    bit auto_cr;

    logic [31:0] s_grant, s_gvc, s_busy, s_cc, s_err;

    function automatic void check(string nm, logic [31:0] act,
                                  logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < V; v++) begin
            m_owner[v] = -1;
            m_cred[v]  = DEPTH;
        end
        m_ptr = 0;
        m_err = 1'b0;
    endfunction

    function automatic int model_win();
        int i, v;
        bit ok;
        for (int k = 0; k < N; k++) begin
            i  = (m_ptr + k) % N;
            v  = i % V;
            ok = bus.req[i] && (!CRED_EN || m_cred[v] > 0) &&
                 ((m_owner[v] < 0 && bus.req_head[i]) ||
                  m_owner[v] == i);
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]      = p_act[i];
            bus.req_head[i] = p_act[i] && p_idx[i] == 0;
            bus.req_tail[i] = p_act[i] && p_idx[i] == p_len[i] - 1;
        end
    endtask

    task automatic start(int i, int len, bit rep);
        p_act[i] = 1'b1;
        p_idx[i] = 0;
        p_len[i] = len;
        p_rep[i] = rep;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            p_act[i] = 1'b0;
            p_rep[i] = 1'b0;
        end
        auto_cr = 1'b0;
        bus.credit_return = '0;
    endtask

    task automatic tick();
        int w, v;
        logic [N-1:0] one, eg, eh, et;
        logic [V-1:0] eb, ecr;
        logic [3:0]   ecc;
        bit dec;
        drive();
        if (auto_cr)
            for (int k = 0; k < V; k++)
                bus.credit_return[k] = CRED_EN && m_cred[k] < DEPTH;
        @(negedge clk);
        if (reset) model_reset();
        w   = reset ? -1 : model_win();
        one = 1;
        eg  = (w >= 0) ? (one << w) : '0;
        for (int k = 0; k < V; k++) begin
            eb[k]          = m_owner[k] >= 0;
            ecc[k*2 +: 2]  = 2'(m_cred[k]);
        end
        eh  = bus.req_head;
        et  = bus.req_tail;
        ecr = bus.credit_return;
        s_grant = 32'(bus.grant);
        s_gvc   = 32'(bus.grant_vc);
        s_busy  = 32'(bus.vc_busy);
        s_cc    = 32'(bus.credit_count);
        s_err   = 32'(bus.credit_error);
        check("grant", s_grant, 32'(eg));
        check("grant_vc", s_gvc, (w >= 0) ? 32'(w % V) : 0);
        check("vc_busy", s_busy, 32'(eb));
        check("credit_count", s_cc, 32'(ecc));
        check("credit_error", s_err, 32'(m_err));
        @(posedge clk);
        if (!reset) begin
            if (w >= 0) begin
                v = w % V;
                if (et[w]) m_owner[v] = -1;
                else if (eh[w]) m_owner[v] = w;
                m_ptr = (w + 1) % N;
                p_idx[w]++;
                if (p_idx[w] == p_len[w]) begin
                    p_act[w] = 1'b0;
                    if (p_rep[w]) start(w, p_len[w], 1'b1);
                end
            end
            if (CRED_EN)
                for (int k = 0; k < V; k++) begin
                    dec = (w >= 0) && (w % V == k);
                    if (ecr[k] && !dec) begin
                        if (m_cred[k] == DEPTH) m_err = 1'b1;
                        else m_cred[k]++;
                    end else if (!ecr[k] && dec) begin
                        m_cred[k]--;
                    end
                end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] exp_rr [4] = '{8'h01, 8'h04, 8'h01, 8'h04};
    logic [7:0] exp_wh [6] = '{8'h02, 8'h10, 8'h02, 8'h10, 8'h02, 8'h08};

    initial begin
        model_reset();
        clear_all();
        drive();

        // reset with every requester offering a single-flit head
        for (int i = 0; i < N; i++) start(i, 1, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        check("rst_grant", s_grant, 0);
        check("rst_busy", s_busy, 0);
        check("rst_credits", s_cc, 32'hA);
        check("rst_error", s_err, 0);
        reset = 1'b0;
        tick();
        check("first_grant", s_grant, 32'h01);

        // round-robin between requesters 0 and 2
        do_reset();
        auto_cr = 1'b1;
        start(0, 1, 1'b1);
        start(2, 1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_grant", s_grant, 32'(exp_rr[k]));
            check("rr_busy", s_busy, 0);
        end

        // wormhole lock on VC1, VC0 interleaves
        do_reset();
        auto_cr = 1'b1;
        start(1, 3, 1'b0);
        start(3, 1, 1'b0);
        start(4, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("wh_grant", s_grant, 32'(exp_wh[k]));
        end

        // credit exhaustion on VC0
        do_reset();
        start(0, 3, 1'b0);
        tick();
        check("ce_flit1", s_grant, 32'h01);
        tick();
        check("ce_flit2", s_grant, 32'h01);
        tick();
`ifdef SPIDERGON_ARB_CREDIT_EN
        check("ce_stall", s_grant, 0);
        check("ce_zero", s_cc & 32'h3, 0);
        bus.credit_return[0] = 1'b1;
        tick();
        check("ce_same_cycle", s_grant, 0);
        bus.credit_return[0] = 1'b0;
        tick();
        check("ce_flit3", s_grant, 32'h01);
`else
        check("ce_flit3", s_grant, 32'h01);
`endif

        // simultaneous grant+return, then saturation
        do_reset();
        start(0, 1, 1'b0);
        tick();
        start(0, 1, 1'b0);
        bus.credit_return[0] = 1'b1;
        tick();
        bus.credit_return[0] = 1'b0;
        tick();
        check("sim_count", s_cc & 32'h3, CRED_EN ? 32'h1 : 32'h2);
        bus.credit_return[0] = 1'b1;
        tick();
        tick();
        bus.credit_return[0] = 1'b0;
        tick();
        check("sat_count", s_cc & 32'h3, 32'h2);
        check("sat_error", s_err, CRED_EN ? 32'h1 : 32'h0);
        tick();
        check("sticky_error", s_err, CRED_EN ? 32'h1 : 32'h0);

        // reset while VC0 is locked to requester 6
        do_reset();
        start(6, 3, 1'b0);
        tick();
        check("mp_head", s_grant, 32'h40);
        reset = 1'b1;
        tick();
        check("mp_busy", s_busy, 0);
        check("mp_credits", s_cc, 32'hA);
        reset = 1'b0;
        tick();
        check("mp_nonhead", s_grant, 0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!p_act[i] && $urandom_range(0, 3) == 0)
                    start(i, int'($urandom_range(1, 3)), 1'b0);
            for (int k = 0; k < V; k++)
                bus.credit_return[k] =
                    (!CRED_EN || m_cred[k] < DEPTH) && ($urandom % 2 == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spidergon_output_arbiter.md
# spidergon_output_arbiter

Switch arbiter for one output port of a Spidergon router node. It shares the port among all input-port virtual channels that request it, one flit per cycle, using round-robin selection. Packets are wormhole-locked onto a downstream virtual channel, and grants are gated by credit-based flow control against the downstream node's VC buffers. Each NoC node instantiates one per output port (local, clockwise, counter-clockwise, across), driving that port's crossbar select.

## Interface
- NUM_OF_INPUT_PORTS, 4, input ports competing for this output (local, cw, ccw, across)
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per port
- FLIT_DATA_WIDTH, 16, flit width in bits
- NODE_BUFFER_WIDTH, 32, bits per downstream VC buffer; DEPTH = NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH flits (2)
- Derived: N = NUM_OF_INPUT_PORTS*NUM_OF_VIRTUAL_CHANNELS requesters; V = NUM_OF_VIRTUAL_CHANNELS; VW = max(1,$clog2(V)); CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  N  requester i has a flit for this port; requester i = port i/V, VC i%V
- req_head  in  N  that flit is a head flit
- req_tail  in  N  that flit is a tail flit (head+tail = single-flit packet)
- credit_return  in  V  one pulse = one freed slot in downstream VC v
- grant  out  N  one-hot or zero, combinational; flit of winner transfers on this edge
- grant_vc  out  VW  downstream VC of the granted flit (winner % V); 0 when no grant
- vc_busy  out  V  downstream VC v is locked to a packet
- credit_count  out  V*CW  current credits per VC, VC0 in LSBs
- credit_error  out  1  sticky: credit returned to a full counter

## Operation
- Downstream VC mapping fixed: requester i uses output VC v = i % V (no VC reallocation).
- Per-VC state: IDLE or LOCKED(owner, clog2(N) bits).
- Requester i eligible when req[i] and credit ok for v and either (v IDLE and req_head[i]) or (v LOCKED and owner==i). Non-head flits of non-owners are never eligible.
- Credit ok: credit_count[v] > 0.
- Round-robin: single pointer ptr over 0..N-1; winner = first eligible index searching ptr, ptr+1, … wrapping mod N. On grant, ptr <= winner+1 mod N (N-1 wraps to 0); no grant leaves ptr unchanged.
- At most one grant per cycle.
- On grant of head with tail=0: v becomes LOCKED(winner).
- On grant with tail=1: v becomes IDLE; single-flit packets never lock.
- Credits: granted VC decrements. credit_return[v] increments. Both in the same cycle leaves the count unchanged. A return at count DEPTH without a grant saturates at DEPTH and sets credit_error.
- Requesters hold req/head/tail stable until granted, and advance only after the granting edge.

## Timing
- Grant latency 0: grant is a combinational function of inputs and registered state; transfer occurs at the rising edge where grant is high.
- Lock, ptr and credit updates take effect the cycle after the granting edge.
- A credit returned in cycle t can enable a grant in cycle t+1 at earliest; it never enables one in t.
- While reset is asserted: grant=0 and grant_vc=0 (forced). All VCs are IDLE, so vc_busy=0. credit_count=DEPTH per VC, ptr=0 and credit_error=0.
- Reset mid-packet discards all locks and refills credits immediately. Upstream and downstream must be reset together.

## Configuration
- SPIDERGON_ARB_CREDIT_EN defined: credit counters, credit gating and credit_error are implemented as above.
- Not defined: no counters. Eligibility ignores credits, credit_return is ignored, credit_count reads DEPTH constant and credit_error is tied 0. Used for infinite-sink bring-up.

## Test plan
- Reset: hold reset 2 cycles with req=8'hFF, heads=1 -> grant=0, vc_busy=0, credit_count={2,2}, credit_error=0; after release, first grant = requester 0.
- Round-robin: requesters 0 and 2 send single-flit packets continuously, credit_return[0] pulsed every grant -> grants 0,2,0,2…, vc_busy[0] stays 0.
- Wormhole lock: requester 1 sends a 3-flit packet on VC1 while requester 3 holds a VC1 head -> 3 is not granted until the cycle after 1's tail; requester 4 (VC0) interleaves meanwhile.
- Credit exhaustion: no credit_return, requester 0 sends a 3-flit packet -> flits 1–2 granted, stall with credit_count[0]=0. A credit_return[0] pulse in cycle t gives the flit-3 grant in t+1.
- Simultaneous events: count=1 with grant plus credit_return in the same cycle -> count stays 1. A return at count 2 -> count 2, credit_error=1 until reset.
- Reset mid-packet: assert reset while VC0 is locked to requester 6 -> vc_busy=0, credits 2. A non-head flit from 6 after release gets no grant.
